// File: rtl/bs_pkg.sv
// bs_pkg: shared FSM state type and slot-index width for the slot scheduler.
package bs_pkg;
  localparam int SLOT_IDX_W = 4;
  typedef enum logic [1:0] {WAIT_PPS, RUN, HOLD, LOST} state_t;
endpackage

// File: rtl/bs_slot_scheduler_if.sv
// bs_slot_scheduler_if: schedule-table write/commit and PPS status bus between the config path and the scheduler.
interface bs_slot_scheduler_if #(parameter int NUM_CH = 8);
  import bs_pkg::*;
  logic                  sched_wr_en;
  logic [SLOT_IDX_W-1:0] sched_wr_slot;
  logic [NUM_CH-1:0]     sched_wr_mask;
  logic                  sched_commit;
  logic                  err_clr;
  logic                  commit_pending;
  logic                  pps_early;
  logic                  pps_lost;
  modport master (
    output sched_wr_en, sched_wr_slot, sched_wr_mask, sched_commit, err_clr,
    input  commit_pending, pps_early, pps_lost
  );
  modport slave (
    input  sched_wr_en, sched_wr_slot, sched_wr_mask, sched_commit, err_clr,
    output commit_pending, pps_early, pps_lost
  );
endinterface

// File: rtl/cdc_direct.sv
// cdc_direct: two-flop synchronizer for quasi-static or slow asynchronous levels.
module cdc_direct #(parameter int WIDTH = 1) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      q <= '0;
    end else begin
      meta <= d;
      q <= meta;
    end
endmodule

// File: rtl/bs_slot_scheduler.sv
// bs_slot_scheduler: PPS-aligned TDMA slot scheduler with double-buffered mask table and PPS supervision.
module bs_slot_scheduler import bs_pkg::*; #(
  parameter int NUM_CH      = 8,
  parameter int NUM_SLOTS   = 4,
  parameter int SLOT_CYCLES = 40920000,
  parameter int PPS_MARGIN  = 81840
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pps_in,
  input  logic [NUM_CH-1:0]     global_enable,
  bs_slot_scheduler_if.slave    cfg,
  output logic [NUM_CH-1:0]     channel_enable_o,
  output logic                  slot_start,
  output logic [SLOT_IDX_W-1:0] slot_idx
);
  localparam int IW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int WW = $clog2(PPS_MARGIN + 1);
  localparam logic [CW-1:0]         CYC_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [WW-1:0]         WD_END    = WW'(PPS_MARGIN);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

  logic pps_sync, pps_d, pps_edge;
  logic wr_ok, copy;
  logic [NUM_CH-1:0] shadow [NUM_SLOTS];
  logic [NUM_CH-1:0] active [NUM_SLOTS];
  state_t state, state_n;
  logic [CW-1:0] cyc_ctr, cyc_n;
  logic [WW-1:0] wd_ctr, wd_n;
  logic [SLOT_IDX_W-1:0] slot_n;
  logic [IW-1:0] nxt_i;
  logic [NUM_CH-1:0] en_n;
  logic start_n, early_n, pend_n;

  cdc_direct #(.WIDTH(1)) u_pps_sync (.clk(clk), .rst_n(rst_n), .d(pps_in), .q(pps_sync));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pps_d <= 1'b0;
      pps_edge <= 1'b0;
    end else begin
      pps_d <= pps_sync;
      pps_edge <= pps_sync & ~pps_d;
    end

  // A commit arriving on the PPS edge itself is applied at that edge.
  assign copy  = pps_edge & (cfg.commit_pending | cfg.sched_commit);
  assign wr_ok = cfg.sched_wr_en && (int'(cfg.sched_wr_slot) < NUM_SLOTS);
  assign nxt_i = slot_idx[IW-1:0] + IW'(1);

  // Copy reads the pre-write shadow, so a same-cycle write only lands in shadow.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (copy) active <= shadow;
      if (wr_ok) shadow[cfg.sched_wr_slot[IW-1:0]] <= cfg.sched_wr_mask;
    end

  always_comb begin
    state_n = state;
    slot_n  = slot_idx;
    cyc_n   = cyc_ctr;
    wd_n    = wd_ctr;
    en_n    = channel_enable_o;
    start_n = 1'b0;
    early_n = (cfg.pps_early & ~cfg.err_clr) | (pps_edge & (state == RUN));
    pend_n  = ~copy & (cfg.commit_pending | cfg.sched_commit);
    if (pps_edge) begin
      state_n = RUN;
      slot_n  = '0;
      cyc_n   = '0;
      start_n = 1'b1;
      en_n    = (copy ? shadow[0] : active[0]) & global_enable;
    end else if (state == RUN) begin
      if (cyc_ctr != CYC_LAST) cyc_n = cyc_ctr + CW'(1);
      else if (slot_idx == LAST_SLOT) begin
        state_n = HOLD;
        wd_n    = '0;
        en_n    = '0;
      end else begin
        slot_n  = slot_idx + SLOT_IDX_W'(1);
        cyc_n   = '0;
        start_n = 1'b1;
        en_n    = active[nxt_i] & global_enable;
      end
    end else if (state == HOLD) begin
      wd_n = wd_ctr + WW'(1);
      state_n = (wd_n == WD_END) ? LOST : HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= WAIT_PPS;
      slot_idx <= '0;
      cyc_ctr <= '0;
      wd_ctr <= '0;
      channel_enable_o <= '0;
      slot_start <= 1'b0;
      cfg.commit_pending <= 1'b0;
      cfg.pps_early <= 1'b0;
      cfg.pps_lost <= 1'b0;
    end else begin
      state <= state_n;
      slot_idx <= slot_n;
      cyc_ctr <= cyc_n;
      wd_ctr <= wd_n;
      channel_enable_o <= en_n;
      slot_start <= start_n;
      cfg.commit_pending <= pend_n;
      cfg.pps_early <= early_n;
      cfg.pps_lost <= (state_n == LOST);
    end
endmodule

// File: tb/tb_bs_slot_scheduler.sv
// tb_bs_slot_scheduler: directed self-checking bench for the PPS slot scheduler (4 slots x 100 cycles, margin 20).
module tb_bs_slot_scheduler;
  localparam int NUM_CH = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pps_in = 1'b0;
  logic [NUM_CH-1:0] global_enable = '0;
  logic [NUM_CH-1:0] channel_enable_o;
  logic slot_start;
  logic [3:0] slot_idx;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_tab [4];

  bs_slot_scheduler_if #(.NUM_CH(NUM_CH)) cfg ();

  bs_slot_scheduler #(.NUM_CH(NUM_CH), .NUM_SLOTS(4), .SLOT_CYCLES(100), .PPS_MARGIN(20)) dut (
    .clk(clk), .rst_n(rst_n), .pps_in(pps_in), .global_enable(global_enable), .cfg(cfg.slave),
    .channel_enable_o(channel_enable_o), .slot_start(slot_start), .slot_idx(slot_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [3:0] s, input logic [7:0] m);
    cfg.sched_wr_en = 1'b1;
    cfg.sched_wr_slot = s;
    cfg.sched_wr_mask = m;
    tick();
    cfg.sched_wr_en = 1'b0;
  endtask

  // Raise PPS and wait (bounded) for the slot 0 start; 4 clocks from pps_in to visible slot_start.
  task automatic pps_sync(input string tag);
    int n = 0;
    pps_in = 1'b1;
    do begin
      tick();
      n++;
    end while (!slot_start && n < 10);
    pps_in = 1'b0;
    chk({tag, "_latency"}, n, 4);
  endtask

  // From a slot 0 start, run len cycles with PPS timed so the next slot 0 starts at cycle len.
  task automatic run_sec(input int len, input int exp_starts, input string tag);
    int bad = 0;
    int starts = 0;
    logic [7:0] e;
    for (int i = 0; i < len; i++) begin
      e = (i < 400) ? exp_tab[i / 100] : 8'h00;
      if (channel_enable_o !== e) bad++;
      if (slot_start) starts++;
      if (i == len - 4) pps_in = 1'b1;
      if (i == len - 1) pps_in = 1'b0;
      tick();
    end
    chk({tag, "_mask_errs"}, bad, 0);
    chk({tag, "_starts"}, starts, exp_starts);
    chk({tag, "_restart"}, {slot_start, slot_idx, channel_enable_o}, {1'b1, 4'd0, exp_tab[0]});
  endtask

  initial begin
    int s;
    int i;
    cfg.sched_wr_en = 1'b0;
    cfg.sched_wr_slot = '0;
    cfg.sched_wr_mask = '0;
    cfg.sched_commit = 1'b0;
    cfg.err_clr = 1'b0;
    skip(3);
    chk("reset_outputs", {channel_enable_o, slot_start, slot_idx, cfg.commit_pending, cfg.pps_early, cfg.pps_lost}, 0);
    rst_n = 1'b1;
    s = 0;
    repeat (20) begin
      tick();
      s += int'(slot_start);
    end
    chk("idle_no_start", s, 0);

    global_enable = 8'hFF;
    wr(0, 8'h01);
    wr(1, 8'h02);
    wr(2, 8'h04);
    wr(3, 8'h08);
    exp_tab = '{8'h01, 8'h02, 8'h04, 8'h08};
    cfg.sched_commit = 1'b1;
    tick();
    cfg.sched_commit = 1'b0;
    chk("commit_pending_set", cfg.commit_pending, 1);
    chk("idle_mask", channel_enable_o, 0);
    pps_sync("first_pps");
    chk("first_mask", channel_enable_o, 8'h01);
    chk("first_pending_clr", cfg.commit_pending, 0);

    run_sec(450, 4, "sec450");
    chk("sec450_lost_clr", cfg.pps_lost, 0);
    chk("sec450_not_early", cfg.pps_early, 0);

    run_sec(250, 3, "early");
    chk("early_set", cfg.pps_early, 1);
    cfg.err_clr = 1'b1;
    tick();
    cfg.err_clr = 1'b0;
    chk("early_clr", cfg.pps_early, 0);

    i = 1;
    while (!cfg.pps_lost && i < 600) begin
      tick();
      i++;
    end
    chk("lost_at", i, 420);
    chk("lost_mask", channel_enable_o, 0);
    pps_sync("lost_exit");
    chk("lost_exit_state", {cfg.pps_lost, cfg.pps_early, slot_idx, channel_enable_o}, {1'b0, 1'b0, 4'd0, 8'h01});

    skip(150);
    wr(0, 8'h80);
    cfg.sched_commit = 1'b1;
    tick();
    cfg.sched_commit = 1'b0;
    chk("mid_pending", cfg.commit_pending, 1);
    chk("mid_old_slot1", channel_enable_o, 8'h02);
    skip(60);
    chk("mid_old_slot2", channel_enable_o, 8'h04);
    cfg.err_clr = 1'b1;
    pps_sync("commit_pps");
    chk("early_set_wins", cfg.pps_early, 1);
    chk("commit_new_slot0", channel_enable_o, 8'h80);
    chk("commit_pending_clr", cfg.commit_pending, 0);
    cfg.err_clr = 1'b0;

    wr(1, 8'h40);
    wr(5, 8'hAA);
    pps_in = 1'b1;
    skip(3);
    cfg.sched_commit = 1'b1;
    cfg.sched_wr_en = 1'b1;
    cfg.sched_wr_slot = 4'd2;
    cfg.sched_wr_mask = 8'h20;
    tick();
    cfg.sched_commit = 1'b0;
    cfg.sched_wr_en = 1'b0;
    pps_in = 1'b0;
    chk("same_edge_start", {slot_start, slot_idx, channel_enable_o}, {1'b1, 4'd0, 8'h80});
    chk("same_edge_pending", cfg.commit_pending, 0);
    skip(100);
    chk("same_edge_new_slot1", channel_enable_o, 8'h40);
    skip(100);
    chk("copy_old_shadow", channel_enable_o, 8'h04);
    skip(100);
    chk("slot3_unchanged", {slot_idx, channel_enable_o}, {4'd3, 8'h08});
    cfg.sched_commit = 1'b1;
    tick();
    cfg.sched_commit = 1'b0;
    pps_sync("recommit_pps");
    skip(200);
    chk("write_landed", channel_enable_o, 8'h20);

    skip(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {channel_enable_o, slot_start, slot_idx, cfg.commit_pending, cfg.pps_early, cfg.pps_lost}, 0);
    tick();
    rst_n = 1'b1;
    s = 0;
    repeat (500) begin
      tick();
      s += int'(slot_start);
    end
    chk("post_reset_no_start", s, 0);
    pps_sync("post_reset_pps");
    chk("post_reset_table_zero", channel_enable_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bs_slot_scheduler.md
# bs_slot_scheduler

Per-second TDMA scheduler for the 8-channel message transmitter. It sits in the RF clock domain between the AXI configuration path (after CDC) and `message_tx`. Aligned to each PPS rising edge, it steps through a programmable table of NUM_SLOTS time slots and drives the per-slot channel-enable mask. It also watches PPS for early, late and lost pulses. Table writes are double-buffered and commit only on a PPS boundary.

## Interface
- NUM_CH, 8: transmit channels; width of masks.
- NUM_SLOTS, 4: slots per second; at most 16.
- SLOT_CYCLES, 40920000: clock cycles per slot (250 ms at 163.68 MHz).
- PPS_MARGIN, 81840: cycles of grace after the last slot ends before PPS is declared lost.

- clk, input, 1: RF clock.
- rst_n, input, 1: reset; one clock; reset is asynchronous and active-low.
- pps_in, input, 1: raw PPS level; asynchronous to clk.
- global_enable, input, NUM_CH: per-channel master enable, ANDed into the output.
- sched_wr_en, input, 1: write one shadow-table entry.
- sched_wr_slot, input, 4: entry index; a write with index ≥ NUM_SLOTS is ignored.
- sched_wr_mask, input, NUM_CH: channel mask for that slot.
- sched_commit, input, 1: pulse; request shadow→active copy at the next PPS.
- channel_enable_o, output, NUM_CH: registered enable mask to `message_tx`.
- slot_start, output, 1: one-cycle pulse on the first cycle of every slot.
- slot_idx, output, 4: current slot index.
- commit_pending, output, 1: a commit is armed and not yet applied.
- pps_early, output, 1: sticky; PPS arrived before the last slot completed.
- pps_lost, output, 1: level; the block is in LOST state.
- err_clr, input, 1: clears pps_early.

## Operation
- PPS input path: 2-flop synchronizer, then a rising-edge detect. `pps_edge` is one cycle long.
- FSM states: WAIT_PPS, RUN, HOLD, LOST. Reset state is WAIT_PPS.
  - WAIT_PPS: outputs are idle. On pps_edge → RUN, slot 0.
  - RUN: cyc_ctr counts 0..SLOT_CYCLES-1. At terminal count:
    - if slot_idx < NUM_SLOTS-1: slot_idx+1, cyc_ctr←0, slot_start.
    - otherwise → HOLD with wd_ctr←0.
  - HOLD: channel_enable_o=0. On pps_edge → RUN, slot 0. If wd_ctr reaches PPS_MARGIN → LOST.
  - LOST: pps_lost=1, channel_enable_o=0. On pps_edge → RUN, slot 0, pps_lost←0.
- pps_edge in RUN: restart at slot 0 and set pps_early. It does not count as lost.
- Output mask: in RUN, channel_enable_o = active[slot_idx] & global_enable. In all other states it is 0.
- Shadow table: written one entry per sched_wr_en. sched_commit sets commit_pending.
  - On pps_edge with commit_pending (any state): copy all entries active←shadow in one cycle, then clear commit_pending.
  - The slot 0 mask driven on that same edge is the new table.
- Simultaneous sched_commit and pps_edge: the commit is applied at this edge.
- Simultaneous sched_wr_en and a commit copy: the copy takes the old shadow value; the write lands in shadow.
- Simultaneous err_clr and a pps_early set: set wins.
- Reset values: all outputs 0, slot_idx=0, both tables all-zero, counters 0, state WAIT_PPS.
- Reset asserted mid-second: immediate return to the reset values. Resume requires a new PPS.
- Arithmetic: cyc_ctr is $clog2(SLOT_CYCLES) bits, wd_ctr is $clog2(PPS_MARGIN+1) bits. Both are unsigned, and neither ever wraps; they are compared with ==.

## Timing
- pps_in rise → pps_edge: 3 clk (2 sync + 1 edge reg).
- pps_edge → slot_start, slot_idx=0, channel_enable_o updated: +1 clk (registered).
- Slot k starts exactly k·SLOT_CYCLES cycles after slot 0 starts.
- channel_enable_o changes only on slot_start cycles, on entering HOLD/LOST, or at reset.
- sched_wr_en → shadow visible: next cycle. No write handshake; one write per cycle is accepted.

## Structure
- Shared package `bs_pkg`: state enum typedef (WAIT_PPS, RUN, HOLD, LOST) and the SLOT_IDX_W=4 constant.
- Sub-module: reuse `cdc_direct` (WIDTH=1) as the PPS synchronizer. Everything else is flat in one module.

## Test plan
Parameters for all scenarios: NUM_SLOTS=4, SLOT_CYCLES=100, PPS_MARGIN=20.
1. Program masks 0x01/0x02/0x04/0x08, commit, set global_enable=0xFF, then PPS every 450 cycles → channel_enable_o reads 0x01,0x02,0x04,0x08 for 100 cycles each, then 0x00 for 50 cycles; four slot_start pulses per second.
2. PPS at 250 cycles → pps_early=1; slot_idx jumps to 0 with mask 0x01; err_clr → pps_early=0.
3. PPS stops → pps_lost=1 exactly 420 cycles after slot 0 starts (400 slot cycles + 20 margin); the next PPS clears it and restarts slot 0.
4. Mid-second, write slot 0 = 0x80 and pulse sched_commit → commit_pending=1 and the old masks continue; at the next PPS slot 0 drives 0x80 and commit_pending=0.
5. sched_commit on the same cycle as pps_edge → new table applied immediately. Write with sched_wr_slot=5 → no table change.
6. rst_n low during slot 2 → all outputs 0 asynchronously; after release, no slot_start until the next PPS.
